// File: rtl/sta_pkg.sv
// Shared definitions for the static timing analyser: controller states,
// default sizing and the result-width helper.
package sta_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INPUT,
    S_SORT,
    S_RELAX,
    S_TRACE,
    S_OUTPUT
  } state_e;

  localparam int DEF_NODES = 16;
  localparam int DEF_EDGES = 32;
  localparam int DEF_DW    = 4;

  // A path visits at most NODES nodes, so DW + clog2(NODES) bits never overflow.
  function automatic int ow_f(input int dw, input int nodes);
    return dw + $clog2(nodes);
  endfunction

endpackage

// File: rtl/sta_param_if.sv
// Frame input / path result bundle between a frame source and sta_param.
interface sta_param_if import sta_pkg::*; #(
  parameter int NODES = DEF_NODES,
  parameter int DW    = DEF_DW
);
  localparam int NW = $clog2(NODES);
  localparam int OW = ow_f(DW, NODES);

  logic          in_valid;
  logic          mode;
  logic [NW-1:0] start_node;
  logic [NW-1:0] end_node;
  logic [DW-1:0] delay;
  logic [NW-1:0] source;
  logic [NW-1:0] destination;
  logic          out_valid;
  logic          err;
  logic [NW-1:0] path;
  logic [OW-1:0] path_delay;

  modport master (
    output in_valid, mode, start_node, end_node, delay, source, destination,
    input  out_valid, err, path, path_delay
  );

  modport slave (
    input  in_valid, mode, start_node, end_node, delay, source, destination,
    output out_valid, err, path, path_delay
  );
endinterface

// File: rtl/sta_topo_sort.sv
// One Kahn step: pick the lowest-index ready node and retire its out-edges.
module sta_topo_sort import sta_pkg::*; #(
  parameter int NODES = DEF_NODES,
  parameter int EDGES = DEF_EDGES,
  parameter int NW    = $clog2(NODES),
  parameter int IW    = $clog2(EDGES + 1)
) (
  input  logic [IW-1:0] indeg_i   [NODES],
  input  logic          visited_i [NODES],
  input  logic [NW-1:0] src_i     [EDGES],
  input  logic [NW-1:0] dst_i     [EDGES],
  output logic          found_o,
  output logic [NW-1:0] sel_o,
  output logic [IW-1:0] indeg_o   [NODES]
);

  always_comb begin
    found_o = 1'b0;
    sel_o   = '0;
    // Scan downwards so the lowest ready index is the one left standing.
    for (int n = NODES - 1; n >= 0; n--) begin
      if (!visited_i[n] && (indeg_i[n] == '0)) begin
        found_o = 1'b1;
        sel_o   = NW'(n);
      end
    end
    for (int n = 0; n < NODES; n++) begin
      indeg_o[n] = indeg_i[n];
    end
    for (int e = 0; e < EDGES; e++) begin
      if (found_o && (src_i[e] == sel_o)) begin
        indeg_o[dst_i[e]] = indeg_o[dst_i[e]] - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sta_param.sv
// Static timing analyser: loads a DAG frame, topologically sorts it, relaxes
// worst/best path costs from start_node and streams the path start..end.
module sta_param import sta_pkg::*; #(
  parameter int NODES = DEF_NODES,
  parameter int EDGES = DEF_EDGES,
  parameter int DW    = DEF_DW
) (
  input  logic       clk,
  input  logic       rst,
  sta_param_if.slave bus
);
  localparam int NW = $clog2(NODES);
  localparam int OW = ow_f(DW, NODES);
  localparam int EW = $clog2(EDGES);
  localparam int IW = $clog2(EDGES + 1);

  logic [DW-1:0] dly_mem   [NODES];
  logic [NW-1:0] src_mem   [EDGES];
  logic [NW-1:0] dst_mem   [EDGES];
  logic [NW-1:0] order_mem [NODES];
  logic [NW-1:0] stack_mem [NODES];

  state_e        state_q, state_d;
  logic [EW-1:0] beat_q, beat_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [NW:0]   sp_q, sp_d;
  logic          mode_q, mode_d;
  logic [NW-1:0] start_q, start_d, end_q, end_d, cur_q, cur_d;
  logic          cyc_q, cyc_d, fail_q, fail_d, first_q, first_d;
  logic [IW-1:0] indeg_q [NODES], indeg_d [NODES];
  logic          visited_q [NODES], visited_d [NODES];
  logic          reach_q [NODES], reach_d [NODES];
  logic [OW-1:0] cost_q [NODES], cost_d [NODES];
  logic [NW-1:0] pred_q [NODES], pred_d [NODES];
  logic          out_valid_q, out_valid_d, err_q, err_d;
  logic [NW-1:0] path_q, path_d;
  logic [OW-1:0] pdly_q, pdly_d;

  logic          cap_en, ord_we, push_we, found;
  logic [NW-1:0] sel, u_node, v_node, sp_m1;
  logic [OW-1:0] cand;
  logic [IW-1:0] indeg_dec [NODES];

  sta_topo_sort #(.NODES(NODES), .EDGES(EDGES), .NW(NW), .IW(IW)) u_topo (
    .indeg_i   (indeg_q),
    .visited_i (visited_q),
    .src_i     (src_mem),
    .dst_i     (dst_mem),
    .found_o   (found),
    .sel_o     (sel),
    .indeg_o   (indeg_dec)
  );

  always_comb begin
    state_d = state_q;  beat_d = beat_q;   cnt_d = cnt_q;   sp_d = sp_q;
    mode_d  = mode_q;   start_d = start_q; end_d = end_q;   cur_d = cur_q;
    cyc_d   = cyc_q;    fail_d = fail_q;   first_d = first_q;
    indeg_d = indeg_q;  visited_d = visited_q;
    reach_d = reach_q;  cost_d = cost_q;   pred_d = pred_q;
    out_valid_d = 1'b0; err_d = 1'b0;      path_d = '0;     pdly_d = '0;
    ord_we  = 1'b0;     push_we = 1'b0;
    u_node  = '0;       v_node = '0;       cand = '0;
    sp_m1   = sp_q[NW-1:0] - 1'b1;
    cap_en  = bus.in_valid && ((state_q == S_IDLE) || (state_q == S_INPUT));

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          mode_d  = bus.mode;
          start_d = bus.start_node;
          end_d   = bus.end_node;
          for (int n = 0; n < NODES; n++) begin
            indeg_d[n]   = '0;
            visited_d[n] = 1'b0;
          end
          indeg_d[bus.destination] = IW'(1);
          beat_d  = EW'(1);
          cnt_d   = '0;
          sp_d    = '0;
          cyc_d   = 1'b0;
          fail_d  = 1'b0;
          first_d = 1'b0;
          state_d = S_INPUT;
        end
      end
      S_INPUT: begin
        if (bus.in_valid) begin
          indeg_d[bus.destination] = indeg_q[bus.destination] + 1'b1;
          if (int'(beat_q) == EDGES - 1) begin
            beat_d  = '0;
            state_d = S_SORT;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_SORT: begin
        if (!found) begin
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_RELAX;
        end else begin
          visited_d[sel] = 1'b1;
          indeg_d        = indeg_dec;
          ord_we         = 1'b1;
          if (int'(cnt_q) == NODES - 1) begin
            cnt_d   = '0;
            state_d = S_RELAX;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // Seed the relaxation with the origin alone; its cost includes its own delay.
        if (state_d == S_RELAX) begin
          for (int n = 0; n < NODES; n++) begin
            reach_d[n] = 1'b0;
            cost_d[n]  = '0;
            pred_d[n]  = '0;
          end
          reach_d[start_q] = 1'b1;
          cost_d[start_q]  = OW'(dly_mem[start_q]);
        end
      end
      S_RELAX: begin
        u_node = order_mem[cnt_q];
        if (!cyc_q && reach_q[u_node]) begin
          for (int e = 0; e < EDGES; e++) begin
            if (src_mem[e] == u_node) begin
              v_node = dst_mem[e];
              cand   = cost_q[u_node] + OW'(dly_mem[v_node]);
              if (!reach_d[v_node] ||
                  (mode_q ? (cand < cost_d[v_node]) : (cand > cost_d[v_node]))) begin
                reach_d[v_node] = 1'b1;
                cost_d[v_node]  = cand;
                pred_d[v_node]  = u_node;
              end
            end
          end
        end
        if (int'(cnt_q) == NODES - 1) begin
          cnt_d   = '0;
          cur_d   = end_q;
          sp_d    = '0;
          fail_d  = cyc_q || !reach_d[end_q];
          state_d = S_TRACE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TRACE: begin
        if (fail_q) begin
          state_d = S_OUTPUT;
        end else begin
          push_we = 1'b1;
          sp_d    = sp_q + 1'b1;
          if (cur_q == start_q) begin
            first_d = 1'b1;
            state_d = S_OUTPUT;
          end else begin
            cur_d = pred_q[cur_q];
          end
        end
      end
      S_OUTPUT: begin
        out_valid_d = 1'b1;
        if (fail_q) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          path_d  = stack_mem[sp_m1];
          sp_d    = sp_q - 1'b1;
          pdly_d  = first_q ? cost_q[end_q] : '0;
          first_d = 1'b0;
          if (sp_q == (NW+1)'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;  beat_q <= '0;   cnt_q <= '0;    sp_q <= '0;
      mode_q  <= 1'b0;    start_q <= '0;  end_q <= '0;    cur_q <= '0;
      cyc_q   <= 1'b0;    fail_q <= 1'b0; first_q <= 1'b0;
      out_valid_q <= 1'b0; err_q <= 1'b0; path_q <= '0;   pdly_q <= '0;
      for (int n = 0; n < NODES; n++) begin
        indeg_q[n]   <= '0;
        visited_q[n] <= 1'b0;
        reach_q[n]   <= 1'b0;
        cost_q[n]    <= '0;
        pred_q[n]    <= '0;
      end
    end else begin
      state_q <= state_d;  beat_q <= beat_d;   cnt_q <= cnt_d;    sp_q <= sp_d;
      mode_q  <= mode_d;   start_q <= start_d; end_q <= end_d;    cur_q <= cur_d;
      cyc_q   <= cyc_d;    fail_q <= fail_d;   first_q <= first_d;
      out_valid_q <= out_valid_d; err_q <= err_d; path_q <= path_d; pdly_q <= pdly_d;
      indeg_q <= indeg_d;  visited_q <= visited_d;
      reach_q <= reach_d;  cost_q <= cost_d;   pred_q <= pred_d;
    end
  end

  // Frame, order and stack storage are fully rewritten before being read.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      src_mem[beat_q] <= bus.source;
      dst_mem[beat_q] <= bus.destination;
      if (int'(beat_q) < NODES) dly_mem[beat_q[NW-1:0]] <= bus.delay;
    end
    if (ord_we)  order_mem[cnt_q] <= sel;
    if (push_we) stack_mem[sp_q[NW-1:0]] <= cur_q;
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.err        = err_q;
  assign bus.path       = path_q;
  assign bus.path_delay = pdly_q;

endmodule

// File: doc/sta_param.md
STA_PARAM -- requirements
Module: sta_param

Interface
REQ-001 SHALL have parameter NODES, default 16, meaning graph node count (power of 2, 4..64).
REQ-002 SHALL have parameter EDGES, default 32, meaning edges per frame (EDGES >= NODES).
REQ-003 SHALL have parameter DW, default 4, meaning node delay width; NW = clog2(NODES); OW = DW + NW.
REQ-004 SHALL have port clk  in  1  the single clock; every flop is clocked on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  in  1  input frame beat qualifier.
REQ-007 SHALL have port mode  in  1  sampled on the first beat only: 0 = worst (longest) path, 1 = best (shortest) path.
REQ-008 SHALL have port start_node  in  NW  sampled on the first beat only: path origin.
REQ-009 SHALL have port end_node  in  NW  sampled on the first beat only: path terminus.
REQ-010 SHALL have port delay  in  DW  delay of node k on beat k, for k < NODES.
REQ-011 SHALL have port source  in  NW  edge source on every beat.
REQ-012 SHALL have port destination  in  NW  edge destination on every beat.
REQ-013 SHALL have port out_valid  out  1  result beat qualifier.
REQ-014 SHALL have port path_delay  out  OW  path cost; valid only on the first out_valid beat, 0 otherwise.
REQ-015 SHALL have port path  out  NW  path nodes, one per beat, start_node first.
REQ-016 SHALL have port err  out  1  asserted with a single out_valid beat when the frame has no result.

Function
REQ-017 SHALL accept exactly EDGES consecutive in_valid beats per frame; in_valid outside state IDLE/INPUT SHALL be ignored.
REQ-018 SHALL implement states IDLE, INPUT, SORT, RELAX, TRACE, OUTPUT; IDLE->INPUT on in_valid; INPUT->SORT after the EDGES-th beat; SORT->RELAX after NODES cycles or on cycle detection; RELAX->TRACE after NODES cycles; TRACE->OUTPUT when start_node is reached; OUTPUT->IDLE after the last path beat.
REQ-019 SHALL, in SORT, each cycle select the lowest-index unvisited node with in-degree 0 and decrement the in-degree of its successors, duplicate edges counted individually.
REQ-020 SHALL flag a cycle when no in-degree-0 unvisited node exists; this includes self-loops.
REQ-021 SHALL, in RELAX, process one node per cycle in topological order, relaxing only nodes reachable from start_node.
REQ-022 SHALL define cost as the sum of the delays of every node on the path, both endpoints included; accumulators are OW bits and cannot overflow.
REQ-023 SHALL replace a predecessor only on a strictly greater (mode 0) or strictly smaller (mode 1) cost, so on ties the earliest-processed predecessor wins.
REQ-024 SHALL, in TRACE, walk the predecessors from end_node to start_node, pushing one node per cycle into a NODES-deep stack.
REQ-025 SHALL, in OUTPUT, pop the stack so the path is emitted start_node..end_node on consecutive out_valid beats, with no gaps.
REQ-026 SHALL, on a cycle or on end_node unreachable, emit one beat with out_valid=1, err=1, path=0, path_delay=0.
REQ-027 SHALL, when start_node == end_node, emit one beat with path=start_node and path_delay=delay[start_node].
REQ-028 SHALL hold out_valid, err, path and path_delay at 0 whenever out_valid is 0.
REQ-029 SHALL assert the first out_valid no later than 3*NODES+2 cycles after the last input beat.
REQ-030 SHALL accept a new frame the cycle after the final output beat.

Reset
REQ-031 SHALL, when rst=1, on the next edge enter IDLE, clear every output, all counters, in-degrees, visited flags, costs, predecessors and the stack pointer.
REQ-032 SHALL discard any frame in progress on mid-operation reset; the first frame after reset SHALL be computed correctly.
REQ-033 SHALL not require a reset on the delay and edge storage arrays.

Structure
REQ-034 SHALL place the state enum, default parameter values and the OW width function in the shared package sta_pkg.
REQ-035 SHALL implement Kahn selection and in-degree update in a single sub-module sta_topo_sort; all other logic is in sta_param.

Verification (NODES=16, EDGES=32, DW=4, start=0, end=1; unused edges padded as 0->2)
REQ-036 SHALL cover the chain case: edges 0->2, 2->1, delays n0=3, n1=5, n2=4, mode 0 -> path 0,2,1; path_delay=12; err=0.
REQ-037 SHALL cover the diamond case: edges 0->2, 2->1, 0->3, 3->4, 4->1, delays n0=1, n1=1, n2=9, n3=2, n4=2 -> mode 0 gives 0,2,1 with 11; mode 1 gives 0,3,4,1 with 6.
REQ-038 SHALL cover the cycle case: add 3->5 and 5->3 -> exactly one beat with err=1 and path=0.
REQ-039 SHALL cover the unreachable case: no edge into node 1 -> one beat with err=1.
REQ-040 SHALL cover reset mid-operation: rst pulsed during RELAX -> out_valid stays 0; the next chain frame still yields 12.
REQ-041 SHALL cover back-to-back frames: a diamond frame issued on the cycle after the final beat of a chain frame -> both results correct, in order.
